// File: rtl/encoder_pkg.sv
// Shared types and helpers for the multi-channel rotary encoder controller.
package encoder_pkg;

  typedef enum logic [1:0] {KEY_IDLE, KEY_PRESS, KEY_LONG} key_state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_CCW, STEP_ERR} step_t;

  function automatic int db_cycles(input int clk_fre, input int db_us);
    return clk_fre / 1_000_000 * db_us;
  endfunction

  function automatic int ms_cycles(input int clk_fre);
    return clk_fre / 1000;
  endfunction

  // AB is {A,B}; CW order is 11->01->00->10->11. mode 0 = x1, 1 = x4.
  function automatic step_t step_dir(input logic [1:0] prev_ab,
                                     input logic [1:0] cur_ab,
                                     input logic       mode);
    step_t s;
    s = STEP_NONE;
    if (prev_ab != cur_ab) begin
      if ((prev_ab[1] ^ cur_ab[1]) && (prev_ab[0] ^ cur_ab[0])) begin
        s = STEP_ERR;
      end else if (!mode) begin
        if (prev_ab[1] && !cur_ab[1]) s = cur_ab[0] ? STEP_CW : STEP_CCW;
      end else begin
        case ({prev_ab, cur_ab})
          4'b1101, 4'b0100, 4'b0010, 4'b1011: s = STEP_CW;
          default:                            s = STEP_CCW;
        endcase
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/encoder_debounce.sv
// Single-bit 2-FF synchroniser followed by a stable-time filter; idles high.
module encoder_debounce #(
  parameter int DB_CYC = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_dout
);
  localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced value matches the filtered one restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(DB_CYC - 1)) filt_d = sync_q[1];
      else                             cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], i_din};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_dout = filt_q;

endmodule

// File: rtl/encoder_multi_ctrl.sv
// Multi-channel rotary encoder controller: debounce, quadrature decode,
// position counting and short/long press classification.
module encoder_multi_ctrl
  import encoder_pkg::*;
#(
  parameter int CLK_FRE   = 50_000_000,
  parameter int CH_NUM    = 2,
  parameter int DB_US     = 5000,
  parameter int STEP_MODE = 0,
  parameter int POS_W     = 8,
  parameter int WRAP      = 1,
  parameter int POS_MAX   = 2**POS_W - 1,
  parameter int LONG_MS   = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [CH_NUM-1:0]       i_enc_a,
  input  logic [CH_NUM-1:0]       i_enc_b,
  input  logic [CH_NUM-1:0]       i_key,
  input  logic [CH_NUM-1:0]       i_clr,
  output logic [CH_NUM-1:0]       o_cw,
  output logic [CH_NUM-1:0]       o_ccw,
  output logic [CH_NUM-1:0]       o_err,
  output logic [CH_NUM*POS_W-1:0] o_pos,
  output logic [CH_NUM-1:0]       o_key_lvl,
  output logic [CH_NUM-1:0]       o_short,
  output logic [CH_NUM-1:0]       o_long
);
  localparam int DB_CYC = db_cycles(CLK_FRE, DB_US);
  localparam int MS_CYC = ms_cycles(CLK_FRE);
  localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int HOLD_W = $clog2(LONG_MS + 1);
  localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
  localparam logic MODE_X4 = (STEP_MODE != 0);

  logic [CH_NUM-1:0] a_f, b_f, key_f;
  logic [MS_W-1:0]   ms_cnt_q;
  logic              tick;

  // One shared prescaler feeds the hold counters of every channel.
  assign tick = (ms_cnt_q == MS_W'(MS_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     ms_cnt_q <= '0;
    else if (tick) ms_cnt_q <= '0;
    else           ms_cnt_q <= ms_cnt_q + 1'b1;
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    logic [1:0]        ab_cur, ab_prev_q;
    step_t             step;
    logic              cw_q, ccw_q, err_q, short_q, long_q, short_d, long_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    key_state_t        key_q, key_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    encoder_debounce #(.DB_CYC(DB_CYC)) u_db_a (
      .i_clk(i_clk), .i_rst(i_rst), .i_din(i_enc_a[n]), .o_dout(a_f[n]));
    encoder_debounce #(.DB_CYC(DB_CYC)) u_db_b (
      .i_clk(i_clk), .i_rst(i_rst), .i_din(i_enc_b[n]), .o_dout(b_f[n]));
    encoder_debounce #(.DB_CYC(DB_CYC)) u_db_k (
      .i_clk(i_clk), .i_rst(i_rst), .i_din(i_key[n]), .o_dout(key_f[n]));

    assign ab_cur = {a_f[n], b_f[n]};
    assign step   = step_dir(ab_prev_q, ab_cur, MODE_X4);

    // Clear wins over a coincident step; the step pulse itself is unaffected.
    always_comb begin
      pos_d = pos_q;
      if (i_clr[n]) begin
        pos_d = '0;
      end else if (step == STEP_CW) begin
        if (WRAP != 0 || pos_q < POS_MAX_V) pos_d = pos_q + 1'b1;
      end else if (step == STEP_CCW) begin
        if (WRAP != 0 || pos_q != '0) pos_d = pos_q - 1'b1;
      end
    end

    always_comb begin
      key_d   = key_q;
      hold_d  = hold_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      case (key_q)
        KEY_IDLE: if (!key_f[n]) begin
          key_d  = KEY_PRESS;
          hold_d = '0;
        end
        KEY_PRESS: if (key_f[n]) begin
          short_d = 1'b1;
          key_d   = KEY_IDLE;
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_W'(LONG_MS - 1)) begin
            long_d = 1'b1;
            key_d  = KEY_LONG;
          end
        end
        KEY_LONG: if (key_f[n]) key_d = KEY_IDLE;
        default:  key_d = KEY_IDLE;
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        ab_prev_q <= 2'b11;
        cw_q      <= 1'b0;
        ccw_q     <= 1'b0;
        err_q     <= 1'b0;
        pos_q     <= '0;
        key_q     <= KEY_IDLE;
        hold_q    <= '0;
        short_q   <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        ab_prev_q <= ab_cur;
        cw_q      <= (step == STEP_CW);
        ccw_q     <= (step == STEP_CCW);
        err_q     <= (step == STEP_ERR);
        pos_q     <= pos_d;
        key_q     <= key_d;
        hold_q    <= hold_d;
        short_q   <= short_d;
        long_q    <= long_d;
      end
    end

    assign o_cw[n]                 = cw_q;
    assign o_ccw[n]                = ccw_q;
    assign o_err[n]                = err_q;
    assign o_pos[n*POS_W +: POS_W] = pos_q;
    assign o_key_lvl[n]            = ~key_f[n];
    assign o_short[n]              = short_q;
    assign o_long[n]               = long_q;
  end

endmodule

// File: tb/tb_encoder_multi_ctrl.sv
// Directed bench: x1/wrap, x4/wrap and x1/saturate instances share the same pins.
module tb_encoder_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] enc_a, enc_b, key, clr;

  logic [1:0] cw[3], ccw[3], err[3], lvl[3], sh[3], lg[3];
  logic [7:0] pos[3];

  int checks = 0;
  int errors = 0;
  int n_cw[3], n_ccw[3], n_err[3], n_sh[3], n_lg[3], n_both[3];

  always #5 clk = ~clk;

  encoder_multi_ctrl #(.CLK_FRE(1_000_000), .CH_NUM(2), .DB_US(10), .STEP_MODE(0),
    .POS_W(4), .WRAP(1), .LONG_MS(2)) u_x1 (
    .i_clk(clk), .i_rst(rst), .i_enc_a(enc_a), .i_enc_b(enc_b), .i_key(key), .i_clr(clr),
    .o_cw(cw[0]), .o_ccw(ccw[0]), .o_err(err[0]), .o_pos(pos[0]), .o_key_lvl(lvl[0]),
    .o_short(sh[0]), .o_long(lg[0]));

  encoder_multi_ctrl #(.CLK_FRE(1_000_000), .CH_NUM(2), .DB_US(10), .STEP_MODE(1),
    .POS_W(4), .WRAP(1), .LONG_MS(2)) u_x4 (
    .i_clk(clk), .i_rst(rst), .i_enc_a(enc_a), .i_enc_b(enc_b), .i_key(key), .i_clr(clr),
    .o_cw(cw[1]), .o_ccw(ccw[1]), .o_err(err[1]), .o_pos(pos[1]), .o_key_lvl(lvl[1]),
    .o_short(sh[1]), .o_long(lg[1]));

  encoder_multi_ctrl #(.CLK_FRE(1_000_000), .CH_NUM(2), .DB_US(10), .STEP_MODE(0),
    .POS_W(4), .WRAP(0), .POS_MAX(3), .LONG_MS(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_enc_a(enc_a), .i_enc_b(enc_b), .i_key(key), .i_clr(clr),
    .o_cw(cw[2]), .o_ccw(ccw[2]), .o_err(err[2]), .o_pos(pos[2]), .o_key_lvl(lvl[2]),
    .o_short(sh[2]), .o_long(lg[2]));

  // Pulses last one full cycle, so counting on the falling edge sees each once.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (cw[d][0])  n_cw[d]++;
      if (ccw[d][0]) n_ccw[d]++;
      if (err[d][0]) n_err[d]++;
      if (sh[d][0])  n_sh[d]++;
      if (lg[d][0])  n_lg[d]++;
      if ((cw[d] & ccw[d]) != 2'b00) n_both[d]++;
    end
  end

  typedef struct {
    logic [1:0] ab;
    int p1, p4, ps, cw1, ccw1, cw4, ccw4, er;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] ab0, input logic [1:0] ab1);
    enc_a = {ab1[1], ab0[1]};
    enc_b = {ab1[0], ab0[0]};
  endtask

  task automatic apply_ab(input logic [1:0] ab0, input logic [1:0] ab1);
    set_ab(ab0, ab1);
    tick(20);
  endtask

  function automatic int p0(input int d);
    return int'(pos[d][3:0]);
  endfunction

  initial begin
    int s_cw[3], s_ccw[3], s_err[3], s_sh, s_lg, first, npulse;

    tbl[0]  = '{2'b01,  1,  1, 1, 1, 0, 1, 0, 0};
    tbl[1]  = '{2'b00,  1,  2, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{2'b10,  1,  3, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{2'b11,  1,  4, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{2'b10,  1,  3, 1, 0, 0, 0, 1, 0};
    tbl[5]  = '{2'b00,  0,  2, 0, 0, 1, 0, 1, 0};
    tbl[6]  = '{2'b01,  0,  1, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{2'b11,  0,  0, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{2'b10,  0, 15, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{2'b00, 15, 14, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{2'b01, 15, 13, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{2'b11, 15, 12, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{2'b00, 15, 12, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{2'b11, 15, 12, 0, 0, 0, 0, 0, 1};

    rst = 1'b1; enc_a = 2'b11; enc_b = 2'b11; key = 2'b11; clr = 2'b00;
    tick(3);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pos[%0d]", d), int'(pos[d]), 0);
      chk($sformatf("rst_pulses[%0d]", d), int'({cw[d], ccw[d], err[d], sh[d], lg[d]}), 0);
      chk($sformatf("rst_lvl[%0d]", d), int'(lvl[d]), 0);
    end
    rst = 1'b0;
    tick(30);
    for (int d = 0; d < 3; d++) chk($sformatf("idle_pos[%0d]", d), int'(pos[d]), 0);

    // Chatter shorter than the filter window must be ignored.
    s_cw[0] = n_cw[0]; s_ccw[0] = n_ccw[0]; s_cw[1] = n_cw[1]; s_ccw[1] = n_ccw[1];
    enc_a[0] = 1'b0; tick(5); enc_a[0] = 1'b1; tick(30);
    chk("chatter_x1_steps", n_cw[0] - s_cw[0] + n_ccw[0] - s_ccw[0], 0);
    chk("chatter_x4_steps", n_cw[1] - s_cw[1] + n_ccw[1] - s_ccw[1], 0);
    chk("chatter_pos", p0(0), 0);

    // A low for 12 cycles: pulse lands on the 13th edge after the pin edge.
    first = -1; npulse = 0;
    enc_a[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (cw[0][0]) begin
        npulse++;
        if (first < 0) first = k;
      end
      if (k == 12) enc_a[0] = 1'b1;
    end
    chk("db_cw_cycle", first, 13);
    chk("db_cw_count", npulse, 1);
    chk("db_pos_x1", p0(0), 1);
    tick(30);
    chk("db_pos_x4_after_return", p0(1), 0);

    clr = 2'b11; tick(1); clr = 2'b00; tick(1);
    for (int d = 0; d < 3; d++) chk($sformatf("clr_pos[%0d]", d), int'(pos[d]), 0);

    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 3; d++) begin
        s_cw[d] = n_cw[d]; s_ccw[d] = n_ccw[d]; s_err[d] = n_err[d];
      end
      apply_ab(tbl[i].ab, 2'b11);
      chk($sformatf("v%0d_pos_x1", i), p0(0), tbl[i].p1);
      chk($sformatf("v%0d_pos_x4", i), p0(1), tbl[i].p4);
      chk($sformatf("v%0d_pos_sat", i), p0(2), tbl[i].ps);
      chk($sformatf("v%0d_cw_x1", i), n_cw[0] - s_cw[0], tbl[i].cw1);
      chk($sformatf("v%0d_ccw_x1", i), n_ccw[0] - s_ccw[0], tbl[i].ccw1);
      chk($sformatf("v%0d_cw_x4", i), n_cw[1] - s_cw[1], tbl[i].cw4);
      chk($sformatf("v%0d_ccw_x4", i), n_ccw[1] - s_ccw[1], tbl[i].ccw4);
      chk($sformatf("v%0d_ccw_sat", i), n_ccw[2] - s_ccw[2], tbl[i].ccw1);
      chk($sformatf("v%0d_err_x1", i), n_err[0] - s_err[0], tbl[i].er);
      chk($sformatf("v%0d_err_x4", i), n_err[1] - s_err[1], tbl[i].er);
    end

    // Five CW detents: x1 15->4 wraps, x4 12->0 wraps, saturating stops at 3.
    s_cw[0] = n_cw[0]; s_cw[2] = n_cw[2];
    for (int i = 0; i < 5; i++) begin
      apply_ab(2'b01, 2'b11); apply_ab(2'b00, 2'b11);
      apply_ab(2'b10, 2'b11); apply_ab(2'b11, 2'b11);
    end
    chk("sat5_pos_x1", p0(0), 4);
    chk("sat5_pos_x4", p0(1), 0);
    chk("sat5_pos_sat", p0(2), 3);
    chk("sat5_cw_sat", n_cw[2] - s_cw[2], 5);
    chk("sat5_cw_x1", n_cw[0] - s_cw[0], 5);

    // Clear lands on the same edge as a CW step.
    set_ab(2'b01, 2'b11);
    tick(12);
    clr = 2'b01;
    tick(1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("clrstep_cw[%0d]", d), int'(cw[d][0]), 1);
      chk($sformatf("clrstep_pos[%0d]", d), p0(d), 0);
    end
    clr = 2'b00;
    apply_ab(2'b00, 2'b11); apply_ab(2'b10, 2'b11); apply_ab(2'b11, 2'b11);
    chk("clrstep_after_x1", p0(0), 0);
    chk("clrstep_after_x4", p0(1), 3);
    chk("clrstep_after_sat", p0(2), 0);

    // Channel 0 CW and channel 1 CCW on the same edge.
    apply_ab(2'b11, 2'b10);
    set_ab(2'b01, 2'b00);
    tick(13);
    chk("indep_cw_x1", int'(cw[0]), 1);
    chk("indep_ccw_x1", int'(ccw[0]), 2);
    chk("indep_cw_x4", int'(cw[1]), 1);
    chk("indep_ccw_x4", int'(ccw[1]), 2);
    apply_ab(2'b00, 2'b01); apply_ab(2'b10, 2'b11); apply_ab(2'b11, 2'b11);

    // Short press: 1000 cycles spans at most one ms tick.
    s_sh = n_sh[0]; s_lg = n_lg[0];
    key[0] = 1'b0; tick(500);
    chk("short_lvl", int'(lvl[0]), 1);
    tick(500);
    key[0] = 1'b1; tick(50);
    chk("short_pulse", n_sh[0] - s_sh, 1);
    chk("short_nolong", n_lg[0] - s_lg, 0);
    chk("short_lvl_rel", int'(lvl[0]), 0);

    // Long press: long fires between 1000 and 2100 cycles, release is silent.
    s_sh = n_sh[0]; s_lg = n_lg[0];
    key[0] = 1'b0; tick(1000);
    chk("long_not_early", n_lg[0] - s_lg, 0);
    tick(1100);
    chk("long_pulse", n_lg[0] - s_lg, 1);
    tick(400);
    key[0] = 1'b1; tick(50);
    chk("long_noshort", n_sh[0] - s_sh, 0);
    chk("long_once", n_lg[0] - s_lg, 1);

    // Reset mid-press aborts; nothing follows after reset release.
    key[0] = 1'b0; tick(500);
    chk("rstkey_lvl_pre", int'(lvl[0]), 1);
    rst = 1'b1; #1;
    chk("rstkey_lvl_in_rst", int'(lvl[0]), 0);
    chk("rstkey_pos_in_rst", int'(pos[1]), 0);
    key[0] = 1'b1; tick(3);
    rst = 1'b0;
    s_sh = n_sh[0]; s_lg = n_lg[0];
    tick(2500);
    chk("rstkey_noshort", n_sh[0] - s_sh, 0);
    chk("rstkey_nolong", n_lg[0] - s_lg, 0);
    chk("rstkey_lvl_post", int'(lvl[0]), 0);

    chk("cw_ccw_exclusive", n_both[0] + n_both[1] + n_both[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
